// File: rtl/key_decoder.sv
// Terminal keyboard decoder: turns raw bytes and ANSI CSI sequences into
// frame-aligned flap pulses, pause/quit state and a malformed-sequence count.
module key_decoder #(
  parameter int unsigned ESC_TIMEOUT = 8,
  parameter int unsigned MAX_PARAMS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       frame_tick,
  output logic       flap,
  output logic       pause,
  output logic       quit,
  output logic [7:0] err_cnt
);

  localparam int unsigned TW = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
  localparam int unsigned PW = ($clog2(MAX_PARAMS + 1) > 0) ? $clog2(MAX_PARAMS + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(ESC_TIMEOUT - 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(MAX_PARAMS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ESC  = 2'd1,
    S_CSI  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          pending_q, pending_d;
  logic          flap_d, pause_d, quit_d, rx_ready_d;
  logic [7:0]    err_cnt_d;

  logic acc;
  logic req;
  logic err_inc;
  logic pause_tgl;
  logic quit_set;
  logic pend_eff;

  assign acc = rx_valid & rx_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pcnt_q    <= '0;
      pending_q <= 1'b0;
      flap      <= 1'b0;
      pause     <= 1'b0;
      quit      <= 1'b0;
      err_cnt   <= 8'd0;
      rx_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pcnt_q    <= pcnt_d;
      pending_q <= pending_d;
      flap      <= flap_d;
      pause     <= pause_d;
      quit      <= quit_d;
      err_cnt   <= err_cnt_d;
      rx_ready  <= rx_ready_d;
    end
  end

  // Byte decode, escape timeout and flap alignment
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pcnt_d    = pcnt_q;
    req       = 1'b0;
    err_inc   = 1'b0;
    pause_tgl = 1'b0;
    quit_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (acc) begin
          case (rx_data)
            8'h20, 8'h77: req       = 1'b1;
            8'h70:        pause_tgl = 1'b1;
            8'h71:        quit_set  = 1'b1;
            8'h1B:        state_d   = S_ESC;
            default:      ;
          endcase
        end
      end
      S_ESC: begin
        if (acc) begin
          timer_d = '0;
          if (rx_data == 8'h5B) begin
            state_d = S_CSI;
            pcnt_d  = '0;
          end else begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CSI: begin
        if (acc) begin
          timer_d = '0;
          if (rx_data >= 8'h30 && rx_data <= 8'h3F) begin
            if (pcnt_q == PCNT_MAX) begin
              err_inc = 1'b1;
              state_d = S_IDLE;
            end else begin
              pcnt_d = pcnt_q + PW'(1);
            end
          end else if (rx_data == 8'h41) begin
            req     = 1'b1;
            state_d = S_IDLE;
          end else if (rx_data >= 8'h40 && rx_data <= 8'h7E) begin
            state_d = S_IDLE;
          end else begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    pause_d    = pause ^ pause_tgl;
    quit_d     = quit | quit_set;
    err_cnt_d  = (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    rx_ready_d = ~quit_d;

    // Requests while paused or quit are dropped; entering pause or quit flushes.
    pend_eff = pending_q | (req & ~pause & ~quit);
    if ((pause_tgl & ~pause) | quit_d) begin
      pend_eff = 1'b0;
    end

    flap_d    = frame_tick & pend_eff;
    pending_d = frame_tick ? 1'b0 : pend_eff;
  end

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: directed scenarios plus randomized byte
// streams, compared against a byte-level behavioural model.
module tb_key_decoder;

  localparam int unsigned ESC_TIMEOUT = 8;
  localparam int unsigned MAX_PARAMS  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic       rx_ready;
  logic       flap;
  logic       pause;
  logic       quit;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  key_decoder #(.ESC_TIMEOUT(ESC_TIMEOUT), .MAX_PARAMS(MAX_PARAMS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_tick(frame_tick), .flap(flap),
    .pause(pause), .quit(quit), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic       pause;
    logic       quit;
    logic       ready;
    logic [7:0] err;
  } stat_t;

  stat_t exp_stat[$];
  int    exp_flap[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  bit    started = 1'b0;

  // Reference model: mode 0 = plain keys, 1 = after ESC, 2 = inside CSI
  int m_mode, m_idle, m_par, m_err;
  bit m_pend, m_pause, m_quit, m_ready;

  always @(posedge clk) cyc <= cyc + 1;

  function void chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function void fail_now(string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function void model_reset();
    m_mode = 0; m_idle = 0; m_par = 0; m_err = 0;
    m_pend = 0; m_pause = 0; m_quit = 0; m_ready = 0;
  endfunction

  function void bump_err();
    if (m_err < 255) m_err++;
    m_mode = 0;
  endfunction

  // Advance the model across one clock edge and queue what the DUT must show.
  function void step(bit v, logic [7:0] d, bit t);
    bit acc;
    bit req;
    bit fl;
    stat_t s;
    acc = v && m_ready;
    req = 0;
    if (acc) begin
      m_idle = 0;
      if (m_mode == 0) begin
        if (d == 8'h20 || d == 8'h77) req = 1;
        else if (d == 8'h70) begin
          m_pause = !m_pause;
          if (m_pause) m_pend = 0;
        end
        else if (d == 8'h71) m_quit = 1;
        else if (d == 8'h1B) m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 8'h5B) begin m_mode = 2; m_par = 0; end
        else bump_err();
      end else begin
        if (d >= 8'h30 && d <= 8'h3F) begin
          m_par++;
          if (m_par > int'(MAX_PARAMS)) bump_err();
        end
        else if (d == 8'h41) begin req = 1; m_mode = 0; end
        else if (d >= 8'h40 && d <= 8'h7E) m_mode = 0;
        else bump_err();
      end
    end else if (m_mode != 0) begin
      m_idle++;
      if (m_idle >= int'(ESC_TIMEOUT)) begin
        if (m_mode == 2) bump_err();
        m_mode = 0;
        m_idle = 0;
      end
    end
    if (req && !m_pause && !m_quit) m_pend = 1;
    if (m_quit) m_pend = 0;
    fl = t && m_pend;
    if (t) m_pend = 0;
    m_ready = !m_quit;
    s.pause = m_pause;
    s.quit  = m_quit;
    s.ready = m_ready;
    s.err   = 8'(m_err);
    exp_stat.push_back(s);
    if (fl) exp_flap.push_back(cyc + 1);
  endfunction

  // Entered and left at a negedge; inputs apply to the next posedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit t);
    rx_valid   = v;
    rx_data    = d;
    frame_tick = t;
    step(v, d, t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    rx_valid   = 1'b1;
    rx_data    = 8'h41;
    frame_tick = 1'b0;
    model_reset();
    started = 1'b1;
    exp_stat.delete();
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(rx_ready), 0);
    chk("rst_flap", int'(flap), 0);
    chk("rst_pause", int'(pause), 0);
    chk("rst_quit", int'(quit), 0);
    chk("rst_err", int'(err_cnt), 0);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
  endtask

  // Monitor: status every cycle, flap pulses matched against expected stamps
  stat_t mon_s;
  always begin
    @(posedge clk);
    #1;
    if (started && rst_n) begin
      if (exp_stat.size() == 0) fail_now("stat_queue_empty");
      else begin
        mon_s = exp_stat.pop_front();
        chk("pause", int'(pause), int'(mon_s.pause));
        chk("quit", int'(quit), int'(mon_s.quit));
        chk("rx_ready", int'(rx_ready), int'(mon_s.ready));
        chk("err_cnt", int'(err_cnt), int'(mon_s.err));
      end
      if (flap) begin
        if (exp_flap.size() == 0) fail_now("unexpected_flap");
        else chk("flap_cycle", cyc, exp_flap.pop_front());
      end
      while (exp_flap.size() > 0 && exp_flap[0] < cyc) begin
        fail_now("missing_flap");
        void'(exp_flap.pop_front());
      end
    end
  end

  logic [7:0] tbl [12] = '{8'h20, 8'h77, 8'h70, 8'h1B, 8'h5B, 8'h41,
                           8'h31, 8'h3B, 8'h42, 8'h78, 8'h7F, 8'h0A};

  initial begin
    @(negedge clk);
    do_reset();
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);

    // Plain keys coalesce into one flap per tick
    cycle(1, 8'h20, 0); cycle(1, 8'h20, 0); cycle(1, 8'h77, 0);
    cycle(0, 8'h00, 1);
    chk("plain_flap", int'(flap), 1);
    cycle(0, 8'h00, 0);
    chk("plain_flap_one_cycle", int'(flap), 0);
    cycle(0, 8'h00, 1);
    chk("plain_no_second_flap", int'(flap), 0);

    // CSI sequences
    cycle(1, 8'h1B, 0); cycle(1, 8'h5B, 0); cycle(1, 8'h41, 0);
    cycle(0, 8'h00, 1);
    chk("csi_up_flap", int'(flap), 1);
    cycle(1, 8'h1B, 0); cycle(1, 8'h5B, 0); cycle(1, 8'h31, 0);
    cycle(1, 8'h3B, 0); cycle(1, 8'h35, 0); cycle(1, 8'h41, 0);
    cycle(0, 8'h00, 1);
    chk("csi_param_up_flap", int'(flap), 1);
    cycle(1, 8'h1B, 0); cycle(1, 8'h5B, 0); cycle(1, 8'h31, 0);
    cycle(1, 8'h32, 0); cycle(1, 8'h33, 0); cycle(1, 8'h34, 0);
    chk("csi_four_params_ok", int'(err_cnt), 0);
    cycle(1, 8'h35, 0);
    chk("csi_too_many_params", int'(err_cnt), 1);
    cycle(1, 8'h1B, 0); cycle(1, 8'h78, 0);
    chk("esc_bad_byte", int'(err_cnt), 2);

    // Timeouts
    cycle(1, 8'h1B, 0);
    repeat (8) cycle(0, 8'h00, 0);
    cycle(1, 8'h20, 0);
    cycle(0, 8'h00, 1);
    chk("esc_timeout_flap", int'(flap), 1);
    chk("esc_timeout_no_err", int'(err_cnt), 2);
    cycle(1, 8'h1B, 0); cycle(1, 8'h5B, 0);
    repeat (7) cycle(0, 8'h00, 0);
    chk("csi_before_timeout", int'(err_cnt), 2);
    cycle(0, 8'h00, 0);
    chk("csi_timeout_err", int'(err_cnt), 3);

    // Pause and quit
    cycle(1, 8'h70, 0);
    chk("pause_on", int'(pause), 1);
    cycle(1, 8'h20, 0); cycle(0, 8'h00, 1);
    chk("paused_no_flap", int'(flap), 0);
    cycle(1, 8'h70, 0);
    chk("pause_off", int'(pause), 0);
    cycle(1, 8'h20, 1);
    chk("tick_same_cycle_flap", int'(flap), 1);
    cycle(0, 8'h00, 0);
    cycle(1, 8'h20, 0);
    cycle(1, 8'h71, 1);
    chk("quit_on_tick_no_flap", int'(flap), 0);
    chk("quit_set", int'(quit), 1);
    chk("quit_ready_low", int'(rx_ready), 0);
    cycle(1, 8'h20, 0); cycle(0, 8'h00, 1);
    chk("quit_no_flap", int'(flap), 0);
    cycle(1, 8'h70, 0);
    chk("quit_ignores_pause", int'(pause), 0);

    // Saturation and reset mid-sequence
    do_reset();
    cycle(0, 8'h00, 0);
    repeat (300) begin
      cycle(1, 8'h1B, 0);
      cycle(1, 8'h78, 0);
    end
    chk("err_saturated", int'(err_cnt), 255);
    cycle(1, 8'h1B, 0); cycle(1, 8'h5B, 0); cycle(1, 8'h31, 0);
    do_reset();
    cycle(0, 8'h00, 0);
    cycle(1, 8'h41, 0);
    cycle(0, 8'h00, 1);
    chk("post_reset_A_ignored", int'(flap), 0);
    chk("post_reset_err", int'(err_cnt), 0);

    // Randomized streams
    for (int r = 0; r < 6; r++) begin
      do_reset();
      cycle(0, 8'h00, 0);
      for (int i = 0; i < 600; i++) begin
        logic [7:0] b;
        bit v;
        bit t;
        b = tbl[$urandom_range(0, 11)];
        if ($urandom_range(0, 4) == 0) b = 8'($urandom);
        if (b == 8'h71 && $urandom_range(0, 9) != 0) b = 8'h20;
        if ($urandom_range(0, 699) == 0) b = 8'h71;
        v = ($urandom_range(0, 2) != 0);
        t = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 39) == 0) begin
          int n;
          n = $urandom_range(5, 11);
          for (int k = 0; k < n; k++) cycle(0, 8'h00, ($urandom_range(0, 7) == 0));
        end
        cycle(v, b, t);
      end
    end

    started = 1'b0;
    chk("flap_queue_drained", exp_flap.size(), 0);
    chk("stat_queue_drained", exp_stat.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
